seq_detector_param: RTL and testbench

- Parametrised serial pattern detector. Next generation of the fixed 1010 detector.
- Runtime-programmable pattern and length (1..MAX_LEN), input-valid qualifier, overlapping or non-overlapping match mode, and a saturating match counter.
- Sits on a serial bit stream beside the ALU datapath; its match pulse feeds interrupt/flag logic.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_detector_param_sat_counter.sv | 24 ++
 rtl/seq_detector_param.sv | 90 +++++++++
 tb/tb_seq_detector_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Default geometry reproduces the legacy 1010 detector.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W = $clog2(DEF_MAX_LEN + 1);
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1010;
    localparam int DEF_LEN = 4;

    // Pattern length of zero is meaningless; oversized lengths cap at the window.
    function automatic int clamp_len(input int l, input int max_len);
        int r;
        r = l;
        if (r < 1) r = 1;
        if (r > max_len) r = max_len;
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with registered match pulse,
// overlap/non-overlap restart and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int RST_LEN = DEF_LEN,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cnt_clr,
    output logic               q,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy_fill
);

    logic [MAX_LEN-1:0] window, window_d, win_shift;
    logic [MAX_LEN-1:0] pattern, pattern_d;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill, fill_d, fill_inc;
    logic [LW-1:0]      len, len_d;
    logic               q_d;
    logic               hit;
    logic               sample;

    // Shift/compare on the post-shift window and pick next state.
    always_comb begin
        window_d  = window;
        pattern_d = pattern;
        fill_d    = fill;
        len_d     = len;
        q_d       = 1'b0;
        sample    = in_valid && !cfg_load;
        win_shift = {window[MAX_LEN-2:0], in};
        fill_inc  = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = (fill_inc >= len) && (((win_shift ^ pattern) & mask) == '0);
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = LW'(clamp_len(int'(cfg_len), MAX_LEN));
            window_d  = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            window_d = win_shift;
            fill_d   = (hit && !overlap) ? '0 : fill_inc;
            q_d      = hit;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            fill      <= '0;
            pattern   <= RST_PATTERN;
            len       <= LW'(RST_LEN);
            q         <= 1'b0;
            busy_fill <= 1'b1;
        end else begin
            window    <= window_d;
            fill      <= fill_d;
            pattern   <= pattern_d;
            len       <= len_d;
            q         <= q_d;
            busy_fill <= (fill_d < len_d);
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (hit && sample),
        .clr  (cnt_clr),
        .cnt  (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param.
// A second instance with CNT_W=2 shares the stimulus to observe saturation.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst_n;
    logic               in;
    logic               in_valid;
    logic               overlap;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cnt_clr;
    logic               q, q2;
    logic [7:0]         cnt;
    logic [1:0]         cnt2;
    logic               busy, busy2;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .q(q),
        .match_count(cnt), .busy_fill(busy)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .q(q2),
        .match_count(cnt2), .busy_fill(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic v, input logic eq,
                          input string tag);
        in = b;
        in_valid = v;
        step();
        chk(tag, {31'd0, q}, {31'd0, eq});
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] l,
                        input logic clr);
        cfg_load = 1'b1;
        cfg_pattern = pat;
        cfg_len = l;
        cnt_clr = clr;
        in = 1'b1;
        in_valid = 1'b1;
        step();
        cfg_load = 1'b0;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        chk("load_q", {31'd0, q}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in = 1'b0;
        in_valid = 1'b0;
        overlap = 1'b1;
        cfg_load = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cnt_clr = 1'b0;
        step();
        chk("rst_q", {31'd0, q}, 32'd0);
        chk("rst_cnt", {24'd0, cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        step();

        // Default 1010, overlapping
        bit_in(1, 1, 0, "ov_b1");
        bit_in(0, 1, 0, "ov_b2");
        bit_in(1, 1, 0, "ov_b3");
        chk("ov_busy3", {31'd0, busy}, 32'd1);
        bit_in(0, 1, 1, "ov_b4");
        chk("ov_busy4", {31'd0, busy}, 32'd0);
        chk("ov_cnt4", {24'd0, cnt}, 32'd1);
        bit_in(1, 1, 0, "ov_b5");
        bit_in(0, 1, 1, "ov_b6");
        chk("ov_cnt", {24'd0, cnt}, 32'd2);
        chk("ov_cnt2", {30'd0, cnt2}, 32'd2);

        // Same stream, non-overlapping
        load(8'b0000_1010, 4'd4, 1'b1);
        chk("clr_cnt", {24'd0, cnt}, 32'd0);
        overlap = 1'b0;
        bit_in(1, 1, 0, "no_b1");
        bit_in(0, 1, 0, "no_b2");
        bit_in(1, 1, 0, "no_b3");
        bit_in(0, 1, 1, "no_b4");
        chk("no_busy4", {31'd0, busy}, 32'd1);
        bit_in(1, 1, 0, "no_b5");
        bit_in(0, 1, 0, "no_b6");
        chk("no_cnt", {24'd0, cnt}, 32'd1);

        // 111, len 3, overlapping; then clamped len 1
        overlap = 1'b1;
        load(8'b0000_0111, 4'd3, 1'b1);
        bit_in(1, 1, 0, "p7_b1");
        bit_in(1, 1, 0, "p7_b2");
        bit_in(1, 1, 1, "p7_b3");
        chk("sat_c1", {30'd0, cnt2}, 32'd1);
        bit_in(1, 1, 1, "p7_b4");
        chk("sat_c2", {30'd0, cnt2}, 32'd2);
        bit_in(1, 1, 1, "p7_b5");
        chk("sat_c3", {30'd0, cnt2}, 32'd3);
        load(8'b0000_0001, 4'd0, 1'b0);
        bit_in(1, 1, 1, "l1_b1");
        chk("sat_c4", {30'd0, cnt2}, 32'd3);
        bit_in(1, 1, 1, "l1_b2");
        chk("sat_c5", {30'd0, cnt2}, 32'd3);
        chk("cnt5", {24'd0, cnt}, 32'd5);
        bit_in(0, 1, 0, "l1_b0");
        cnt_clr = 1'b1;
        bit_in(1, 1, 1, "clr_hit_q");
        cnt_clr = 1'b0;
        chk("clr_hit_cnt", {24'd0, cnt}, 32'd0);
        chk("clr_hit_cnt2", {30'd0, cnt2}, 32'd0);

        // Oversized length clamps to MAX_LEN
        load(8'b1111_1111, 4'd15, 1'b0);
        for (int i = 0; i < 7; i++) bit_in(1, 1, 0, "cl_pre");
        bit_in(1, 1, 1, "cl_b8");

        // in_valid toggling with garbage on idle cycles
        load(8'b0000_1010, 4'd4, 1'b1);
        bit_in(1, 1, 0, "iv_1");
        bit_in(1, 0, 0, "iv_2");
        bit_in(0, 1, 0, "iv_3");
        bit_in(1, 0, 0, "iv_4");
        bit_in(1, 1, 0, "iv_5");
        bit_in(0, 0, 0, "iv_6");
        bit_in(0, 1, 1, "iv_7");
        bit_in(0, 0, 0, "iv_8");
        chk("iv_cnt", {24'd0, cnt}, 32'd1);

        // Reset mid-pattern after a custom config
        load(8'b0000_0111, 4'd3, 1'b0);
        bit_in(1, 1, 0, "rs_1");
        bit_in(0, 1, 0, "rs_2");
        bit_in(1, 1, 0, "rs_3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_q", {31'd0, q}, 32'd0);
        chk("rs_cnt", {24'd0, cnt}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd1);
        step();
        rst_n = 1'b1;
        bit_in(0, 1, 0, "rs_0");
        bit_in(1, 1, 0, "rs_a");
        bit_in(0, 1, 0, "rs_b");
        bit_in(1, 1, 0, "rs_c");
        bit_in(0, 1, 1, "rs_d");
        chk("rs_cnt_end", {24'd0, cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
